// File: rtl/branch_predict_resolve.sv
// branch_predict_resolve: resolves execute-stage branches, trains a bimodal
// 2-bit counter table read by fetch, and keeps saturating branch statistics.
module branch_predict_resolve #(
   parameter int          XLEN        = 32,
   parameter int          BHT_ENTRIES = 64,
   parameter logic [1:0]  INIT_CNT    = 2'b01,
   parameter int          STAT_W      = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [XLEN-1:0]   pc_f,
   output logic              pred_taken_f,
   input  logic              valid_e,
   input  logic [XLEN-1:0]   pc_e,
   input  logic [6:0]        opcode_e,
   input  logic [2:0]        br_type_e,
   input  logic [XLEN-1:0]   rs1_e,
   input  logic [XLEN-1:0]   rs2_e,
   input  logic              pred_taken_e,
   output logic              br_taken_e,
   output logic              mispredict,
   output logic [XLEN-1:0]   mispredict_pc,
   output logic [STAT_W-1:0] br_count,
   output logic [STAT_W-1:0] mp_count
);
   localparam int IDX_W = $clog2(BHT_ENTRIES);

   logic [1:0]        bht_q [BHT_ENTRIES];
   logic [1:0]        cnt_d;
   logic [IDX_W-1:0]  idx_f;
   logic [IDX_W-1:0]  idx_e;
   logic              is_br;
   logic              is_jump;
   logic              cond;
   logic              cmp;
   logic              taken;
   logic              mis;
   logic              mis_q;
   logic [XLEN-1:0]   mis_pc_q;
   logic [STAT_W-1:0] br_cnt_q;
   logic [STAT_W-1:0] mp_cnt_q;
   logic              unused_pc_f;

   assign idx_f       = pc_f[IDX_W+1:2];
   assign idx_e       = pc_e[IDX_W+1:2];
   assign unused_pc_f = ^{pc_f[XLEN-1:IDX_W+2], pc_f[1:0]};

   assign pred_taken_f = bht_q[idx_f][1];

   // funct3 010/011 are the only illegal conditional encodings
   assign is_br   = opcode_e == 7'b1100011;
   assign is_jump = opcode_e == 7'b1101111 || opcode_e == 7'b1100111;
   assign cond    = valid_e && is_br && (br_type_e[2] || !br_type_e[1]);

   // bit 0 of funct3 inverts the base comparison (EQ/LT/LTU)
   always_comb begin
      cmp   = br_type_e[2] ? (br_type_e[1] ? (rs1_e < rs2_e) : ($signed(rs1_e) < $signed(rs2_e)))
                           : (rs1_e == rs2_e);
      taken = cmp ^ br_type_e[0];
      br_taken_e = cond ? taken : (valid_e && is_jump);
      mis   = cond && (br_taken_e != pred_taken_e);
      cnt_d = br_taken_e ? ((bht_q[idx_e] == 2'b11) ? 2'b11 : bht_q[idx_e] + 2'd1)
                         : ((bht_q[idx_e] == 2'b00) ? 2'b00 : bht_q[idx_e] - 2'd1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= INIT_CNT;
      end else if (cond) begin
         bht_q[idx_e] <= cnt_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_cnt_q <= '0;
         mp_cnt_q <= '0;
         mis_q    <= 1'b0;
         mis_pc_q <= '0;
      end else begin
         mis_q <= mis;
         if (mis) mis_pc_q <= pc_e;
         if (cond) br_cnt_q <= br_cnt_q + STAT_W'(!(&br_cnt_q));
         if (mis) mp_cnt_q <= mp_cnt_q + STAT_W'(!(&mp_cnt_q));
      end
   end

   assign mispredict    = mis_q;
   assign mispredict_pc = mis_pc_q;
   assign br_count      = br_cnt_q;
   assign mp_count      = mp_cnt_q;
endmodule

// File: tb/tb_branch_predict_resolve.sv
// tb_branch_predict_resolve: directed literal checks plus randomized traffic
// compared every cycle against a behavioural predictor/statistics model.
module tb_branch_predict_resolve;
   localparam int SMAX = 15;

   logic        clk, rst_n;
   logic [31:0] pc_f, pc_e, rs1_e, rs2_e, mispredict_pc;
   logic [6:0]  opcode_e;
   logic [2:0]  br_type_e;
   logic        valid_e, pred_taken_e, pred_taken_f, br_taken_e, mispredict;
   logic [3:0]  br_count, mp_count;

   int vec = 0;
   int err = 0;

   int          bht_m [4];
   int          br_m, mp_m;
   bit          mis_m;
   logic [31:0] mpc_m;

   branch_predict_resolve #(.XLEN(32), .BHT_ENTRIES(4), .INIT_CNT(2'b01), .STAT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .pc_f(pc_f), .pred_taken_f(pred_taken_f),
      .valid_e(valid_e), .pc_e(pc_e), .opcode_e(opcode_e), .br_type_e(br_type_e),
      .rs1_e(rs1_e), .rs2_e(rs2_e), .pred_taken_e(pred_taken_e),
      .br_taken_e(br_taken_e), .mispredict(mispredict), .mispredict_pc(mispredict_pc),
      .br_count(br_count), .mp_count(mp_count)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      vec++;
      if (a !== e) begin
         err++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
      end
   endtask

   function automatic bit m_cond(bit v, logic [6:0] op, logic [2:0] f3);
      return v && op == 7'h63 && f3 != 3'd2 && f3 != 3'd3;
   endfunction

   function automatic bit m_taken(bit v, logic [6:0] op, logic [2:0] f3, logic [31:0] a, logic [31:0] b);
      if (!v) return 0;
      if (op == 7'h6F || op == 7'h67) return 1;
      if (op != 7'h63) return 0;
      case (f3)
         3'd0: return a == b;
         3'd1: return a != b;
         3'd4: return $signed(a) < $signed(b);
         3'd5: return $signed(a) >= $signed(b);
         3'd6: return a < b;
         3'd7: return a >= b;
         default: return 0;
      endcase
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) bht_m[i] <= 1;
         br_m  <= 0;
         mp_m  <= 0;
         mis_m <= 0;
         mpc_m <= 0;
      end else begin
         bit t, c, m;
         c = m_cond(valid_e, opcode_e, br_type_e);
         t = m_taken(valid_e, opcode_e, br_type_e, rs1_e, rs2_e);
         m = c && (t != pred_taken_e);
         mis_m <= m;
         if (m) mpc_m <= pc_e;
         if (c) begin
            br_m <= (br_m < SMAX) ? br_m + 1 : SMAX;
            bht_m[pc_e[3:2]] <= t ? ((bht_m[pc_e[3:2]] < 3) ? bht_m[pc_e[3:2]] + 1 : 3)
                                  : ((bht_m[pc_e[3:2]] > 0) ? bht_m[pc_e[3:2]] - 1 : 0);
         end
         if (m) mp_m <= (mp_m < SMAX) ? mp_m + 1 : SMAX;
      end
   end

   always @(negedge clk) begin
      chk("pred_taken_f", pred_taken_f, bht_m[pc_f[3:2]] >= 2);
      chk("br_taken_e", br_taken_e, m_taken(valid_e, opcode_e, br_type_e, rs1_e, rs2_e));
      chk("mispredict", mispredict, mis_m);
      chk("mispredict_pc", mispredict_pc, mpc_m);
      chk("br_count", br_count, br_m);
      chk("mp_count", mp_count, mp_m);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic br(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] b, input logic p);
      valid_e = 1; opcode_e = op; br_type_e = f3; rs1_e = a; rs2_e = b; pred_taken_e = p;
   endtask

   initial begin
      logic [2:0] ty [4];
      logic       ex [4];
      ty = '{3'd4, 3'd5, 3'd6, 3'd7};
      ex = '{1'b1, 1'b0, 1'b0, 1'b1};
      rst_n = 0; pc_f = 0; pc_e = 0; rs1_e = 0; rs2_e = 0;
      opcode_e = 0; br_type_e = 0; valid_e = 0; pred_taken_e = 0;
      repeat (2) cyc();
      chk("rst mispredict", mispredict, 0);
      chk("rst br_count", br_count, 0);
      chk("rst mp_count", mp_count, 0);
      for (int k = 0; k < 4; k++) begin
         pc_f = k * 4;
         #1 chk("rst pred_f", pred_taken_f, 0);
      end
      rst_n = 1;

      pc_e = 32'h100; pc_f = 32'h100;
      br(7'h63, 3'd0, 5, 5, 0);
      #1 chk("beq taken", br_taken_e, 1);
      chk("train pred0", pred_taken_f, 0);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("train mispredict", mispredict, 1);
         chk("train mp_pc", mispredict_pc, 32'h100);
         chk("train pred", pred_taken_f, 1);
      end
      valid_e = 0;
      cyc();
      chk("train pulse end", mispredict, 0);
      chk("train br_count", br_count, 3);
      chk("train mp_count", mp_count, 3);

      for (int i = 0; i < 4; i++) begin
         br(7'h63, ty[i], 32'hFFFF_FFFF, 1, 0);
         #1 chk("signed cmp", br_taken_e, ex[i]);
         cyc();
      end
      br(7'h63, 3'd2, 32'hFFFF_FFFF, 1, 0);
      #1 chk("illegal f3", br_taken_e, 0);
      cyc();
      chk("illegal mispredict", mispredict, 0);
      chk("illegal br_count", br_count, 7);
      chk("illegal mp_count", mp_count, 5);

      br(7'h6F, 3'd0, 1, 2, 1);
      #1 chk("jal", br_taken_e, 1);
      cyc();
      chk("jal mispredict", mispredict, 0);
      br(7'h67, 3'd0, 1, 2, 0);
      #1 chk("jalr", br_taken_e, 1);
      cyc();
      chk("jalr mispredict", mispredict, 0);
      br(7'h33, 3'd0, 1, 1, 1);
      #1 chk("alu op", br_taken_e, 0);
      cyc();
      chk("jump br_count", br_count, 7);
      chk("jump mp_count", mp_count, 5);
      chk("jump mp_pc", mispredict_pc, 32'h100);

      pc_f = 32'h110;
      br(7'h63, 3'd0, 1, 2, 1);
      #1 chk("alias pre", pred_taken_f, 1);
      chk("alias taken", br_taken_e, 0);
      cyc();
      chk("alias post", pred_taken_f, 0);
      chk("alias mispredict", mispredict, 1);
      chk("alias br_count", br_count, 8);
      chk("alias mp_count", mp_count, 6);
      valid_e = 0;

      for (int i = 0; i < 400; i++) begin
         cyc();
         if (i == 200) begin
            #2 rst_n = 0;
            #1 chk("async rst br_count", br_count, 0);
            chk("async rst mp_count", mp_count, 0);
            chk("async rst mispredict", mispredict, 0);
            chk("async rst mp_pc", mispredict_pc, 0);
            chk("async rst pred_f", pred_taken_f, 0);
         end
         if (i == 203) rst_n = 1;
         valid_e      = $urandom_range(0, 3) != 0;
         case ($urandom_range(0, 7))
            0: opcode_e = 7'h6F;
            1: opcode_e = 7'h67;
            2: opcode_e = 7'(($urandom));
            default: opcode_e = 7'h63;
         endcase
         br_type_e    = 3'($urandom);
         rs1_e        = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 3);
         rs2_e        = $urandom_range(0, 3) == 0 ? rs1_e : ($urandom_range(0, 1) ? $urandom : $urandom_range(0, 3));
         pred_taken_e = 1'($urandom);
         pc_e         = ($urandom & 32'hFFFF_FFFC);
         pc_f         = $urandom_range(0, 1) ? pc_e : $urandom;
      end

      #2 rst_n = 0;
      #3 rst_n = 1;
      for (int i = 0; i < 20; i++) begin
         pc_e = 32'(i * 4);
         br(7'h63, 3'd0, 7, 7, 0);
         cyc();
      end
      chk("sat br_count", br_count, 15);
      chk("sat mp_count", mp_count, 15);
      repeat (3) cyc();
      chk("sat hold br_count", br_count, 15);
      chk("sat hold mp_count", mp_count, 15);
      valid_e = 0;
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end
endmodule

// File: doc/branch_predict_resolve.md
# branch_predict_resolve

Parametrised branch-resolution unit with an integrated bimodal predictor, successor to the combinational branch-condition evaluator. The fetch stage reads a prediction for the current PC. The execute stage presents resolved branch operands, and the block does the following:
- evaluates the condition combinationally;
- trains a table of 2-bit saturating counters;
- flags mispredictions one cycle later;
- keeps saturating performance counters.

## Interface
Parameters:
- XLEN, 32, operand and PC width
- BHT_ENTRIES, 64, predictor entries; power of two, ≥2; IDX_W = log2(BHT_ENTRIES)
- INIT_CNT, 2'b01, reset value of every counter (weakly not-taken)
- STAT_W, 32, width of performance counters

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- pc_f  in  XLEN  fetch PC to predict
- pred_taken_f  out  1  combinational prediction for pc_f
- valid_e  in  1  execute-stage instruction valid
- pc_e  in  XLEN  execute PC
- opcode_e  in  7  instruction opcode
- br_type_e  in  3  funct3 branch type
- rs1_e, rs2_e  in  XLEN  operands
- pred_taken_e  in  1  prediction carried down the pipe for this instruction
- br_taken_e  out  1  combinational resolved direction
- mispredict  out  1  registered misprediction flag
- mispredict_pc  out  XLEN  registered pc_e of mispredicted branch
- br_count  out  STAT_W  resolved conditional branches
- mp_count  out  STAT_W  mispredictions

## Operation
- Index: idx = pc[IDX_W+1:2], used for both ports.
- pred_taken_f = bht[idx(pc_f)][1].
- Conditional branch (cond) is defined as valid_e && opcode_e==7'b1100011 && br_type_e ∈ {000,001,100,101,110,111}.
- Conditions (funct3 encoding):
  - 000 BEQ: rs1==rs2
  - 001 BNE: rs1!=rs2
  - 100 BLT: signed rs1<rs2
  - 101 BGE: signed rs1≥rs2
  - 110 BLTU: unsigned rs1<rs2
  - 111 BGEU: unsigned rs1≥rs2
  - 010 and 011 are illegal: br_taken_e=0, not cond, no update.
- JAL (1101111) and JALR (1100111) with valid_e give br_taken_e=1. They cause no BHT update, no stats and no mispredict.
- Any other opcode, or valid_e=0, gives br_taken_e=0.
- BHT update on cond:
  - taken: counter+1, saturating at 2'b11.
  - not taken: counter−1, saturating at 2'b00.
- Stats on cond:
  - br_count+1.
  - If br_taken_e != pred_taken_e, mp_count+1.
  - Both counters saturate at all-ones and never wrap.
- Mispredict register: each cycle, mispredict <= cond && (br_taken_e != pred_taken_e). mispredict_pc <= pc_e when set; otherwise it holds its value.

## Timing
- pred_taken_f and br_taken_e are purely combinational, with zero latency.
- Table, stats and mispredict update on the rising clk edge after the resolving cycle. mispredict is a one-cycle pulse per mispredicted branch.
- Back-to-back cond every cycle is supported, with one update per cycle and no stalls.
- Same-cycle read/write of the same index: pred_taken_f returns the pre-update value, with no bypass. The new value is visible the next cycle.
- Reset (rst_n=0), asynchronous and applicable at any time including mid-stream:
  - all BHT entries=INIT_CNT;
  - br_count=0, mp_count=0;
  - mispredict=0, mispredict_pc=0.
  - An in-flight resolve in the cycle rst_n is low is discarded.
- After rst_n deasserts, the first update occurs on the first rising edge with cond=1.

## Test plan
- Reset: assert rst_n=0 mid-training.
  - Required response: immediately mispredict=0, counts=0. Every pc_f gives pred_taken_f=0 (INIT 01).
- Training, with pc_e=0x100, BEQ, rs1=rs2=5, pred_taken_e=0 each cycle for 3 cycles:
  - mispredict pulses on cycles 1–3.
  - The counter goes 01→10→11→11, so pred_taken_f(0x100)=1 after the first edge.
  - br_count=3, mp_count=3.
- Signedness, rs1=0xFFFFFFFF, rs2=1:
  - BLT→1, BGE→0, BLTU→0, BGEU→1.
  - br_type 010 → 0, with no count change.
- Jumps and non-branches: JAL and JALR give br_taken_e=1, and opcode 0110011 gives 0. In all three cases the counts, BHT and mispredict are unchanged.
- Aliasing/collision with BHT_ENTRIES=4:
  - Resolve pc_e=0x100 as taken while pc_f=0x110 (same idx 0) in the same cycle.
  - pred_taken_f shows the old value, then the updated value the next cycle.
- Saturation with STAT_W=4: run 20 mispredicted cond branches. Required response: br_count=mp_count=15 and holds.
